trace_multi: RTL and testbench

Multi-channel, change-triggered trace capture buffer that supersedes the single-channel trace block. Up to CHANNELS probe inputs are each filtered by a per-channel change detector and arbitrated round-robin into one BRAM ring. Each stored entry carries a channel id and a timestamp. Captured entries are streamed out to the host bus as OWIDTH-bit words through an ENA/RDY method pair. The block sits between debug probe points and the bus-side readout adapter.

---
 rtl/trace_multi.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_trace_multi.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_multi.sv
`timescale 1ns/1ps
// trace_multi: multi-channel, change-triggered trace capture buffer.
//
// Each probe channel has a change detector that compares the upper
// SENSITIVITY bits of a sample against the last value it accepted. An
// accepted sample is parked in a per-channel holding register. A round-robin
// arbiter moves at most one holding register per cycle into a BRAM ring.
// While frozen, the ring is streamed out as OWIDTH-bit words: the header
// {chan, ts} first, then the data words from most to least significant.
//
// Ports ('$' in the bus method names is written as '_'):
//   CLK, RST                 clock, synchronous active-high reset
//   probe_enable/probe_data  per-channel sample valid and data
//   ctl_arm__ENA             clear the buffer and start capture
//   ctl_stop__ENA            freeze capture
//   ctl_ring                 0 one-shot fill, 1 ring overwrite (sampled at arm)
//   out_first(__RDY)         current output word and its valid
//   out_deq__ENA/__RDY       consume the current word
//   status_*                 state, entries held, dropped samples, wrapped flag
module trace_multi #(
    parameter int CHANNELS    = 4,
    parameter int WIDTH       = 64,
    parameter int DEPTH       = 1024,
    parameter int SENSITIVITY = 32,
    parameter int OWIDTH      = 32
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [CHANNELS-1:0]           probe_enable,
    input  logic [CHANNELS*WIDTH-1:0]     probe_data,
    input  logic                          ctl_arm__ENA,
    input  logic                          ctl_stop__ENA,
    input  logic                          ctl_ring,
    output logic [OWIDTH-1:0]             out_first,
    output logic                          out_first__RDY,
    input  logic                          out_deq__ENA,
    output logic                          out_deq__RDY,
    output logic [1:0]                    status_state,
    output logic [$clog2(DEPTH):0]        status_count,
    output logic [15:0]                   status_dropped,
    output logic                          status_wrapped
);

    localparam int EW     = WIDTH + 32;
    localparam int NWORDS = EW / OWIDTH;
    localparam int AW     = $clog2(DEPTH);
    localparam int CW     = AW + 1;
    localparam int CHW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int WIW    = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_FROZEN  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [23:0]            ts_q, ts_d;
    logic [SENSITIVITY-1:0] last_q [CHANNELS];
    logic [SENSITIVITY-1:0] last_d [CHANNELS];
    logic [CHANNELS-1:0]    last_valid_q, last_valid_d;
    logic [EW-1:0]          hold_q [CHANNELS];
    logic [EW-1:0]          hold_d [CHANNELS];
    logic [CHANNELS-1:0]    hold_valid_q, hold_valid_d;
    logic [CHW-1:0]         rr_next_q, rr_next_d;
    logic [AW-1:0]          wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic [15:0]            dropped_q, dropped_d;
    logic                   wrapped_q, wrapped_d;
    logic                   ring_q, ring_d;
    logic [EW-1:0]          stage_q, stage_d;
    logic                   stage_valid_q, stage_valid_d;
    logic [WIW-1:0]         word_idx_q, word_idx_d;
    logic                   rd_pending_q, rd_pending_d;

    logic [EW-1:0]          mem [DEPTH];
    logic [EW-1:0]          rd_data_q;

    logic [WIDTH-1:0]       probe_word  [CHANNELS];
    logic [SENSITIVITY-1:0] probe_upper [CHANNELS];
    logic [OWIDTH-1:0]      stage_words [NWORDS];

    logic                   grant_valid;
    logic [CHW-1:0]         grant;
    logic [CHW-1:0]         rr_idx;
    logic                   wr_en;
    logic                   rd_issue;
    logic [16:0]            drop_sum;
    int                     drops;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_probe
        assign probe_word[g]  = probe_data[g*WIDTH +: WIDTH];
        assign probe_upper[g] = probe_data[g*WIDTH + WIDTH - 1 -: SENSITIVITY];
    end

    for (genvar k = 0; k < NWORDS; k++) begin : g_words
        assign stage_words[k] = stage_q[EW - 1 - k*OWIDTH -: OWIDTH];
    end

    // Round-robin pick: scan from rr_next_q, which always points one past the
    // most recently granted channel (0 after reset/arm so channel 0 leads).
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        rr_idx      = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            rr_idx = CHW'((int'(rr_next_q) + i) % CHANNELS);
            if (!grant_valid && hold_valid_q[rr_idx]) begin
                grant       = rr_idx;
                grant_valid = 1'b1;
            end
        end
    end

    // One-shot mode never writes into a full ring; ring mode overwrites.
    assign wr_en = (state_q == ST_CAPTURE) && !ctl_arm__ENA && grant_valid &&
                   (ring_q || (count_q != CW'(DEPTH)));

    always_comb begin
        state_d       = state_q;
        ts_d          = ts_q + 24'd1;
        last_d        = last_q;
        last_valid_d  = last_valid_q;
        hold_d        = hold_q;
        hold_valid_d  = hold_valid_q;
        rr_next_d     = rr_next_q;
        wptr_d        = wptr_q;
        rptr_d        = rptr_q;
        count_d       = count_q;
        dropped_d     = dropped_q;
        wrapped_d     = wrapped_q;
        ring_d        = ring_q;
        stage_d       = stage_q;
        stage_valid_d = stage_valid_q;
        word_idx_d    = word_idx_q;
        rd_pending_d  = rd_pending_q;
        rd_issue      = 1'b0;
        drops         = 0;
        drop_sum      = '0;

        if (ctl_arm__ENA) begin
            // Arm beats everything, including a simultaneous stop.
            state_d       = ST_CAPTURE;
            ts_d          = '0;
            last_valid_d  = '0;
            hold_valid_d  = '0;
            rr_next_d     = '0;
            wptr_d        = '0;
            rptr_d        = '0;
            count_d       = '0;
            dropped_d     = '0;
            wrapped_d     = 1'b0;
            ring_d        = ctl_ring;
            stage_valid_d = 1'b0;
            word_idx_d    = '0;
            rd_pending_d  = 1'b0;
        end else begin
            case (state_q)
                ST_CAPTURE: begin
                    if (wr_en) begin
                        hold_valid_d[grant] = 1'b0;
                        rr_next_d = CHW'((int'(grant) + 1) % CHANNELS);
                        wptr_d    = wptr_q + 1'b1;
                        if (count_q == CW'(DEPTH)) begin
                            rptr_d    = rptr_q + 1'b1;
                            wrapped_d = 1'b1;
                        end else begin
                            count_d = count_q + 1'b1;
                        end
                    end
                    // Uses hold_valid_d so a register emptied by this cycle's
                    // grant can be refilled immediately.
                    for (int c = 0; c < CHANNELS; c++) begin
                        if (probe_enable[c] &&
                            (!last_valid_q[c] || (probe_upper[c] != last_q[c]))) begin
                            if (!hold_valid_d[c]) begin
                                hold_d[c]       = {8'(c), ts_q, probe_word[c]};
                                hold_valid_d[c] = 1'b1;
                                last_d[c]       = probe_upper[c];
                                last_valid_d[c] = 1'b1;
                            end else begin
                                drops = drops + 1;
                            end
                        end
                    end
                    drop_sum  = {1'b0, dropped_q} + 17'(drops);
                    dropped_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
                    if (ctl_stop__ENA || (!ring_q && (count_d == CW'(DEPTH)))) begin
                        state_d      = ST_FROZEN;
                        hold_valid_d = '0;
                    end
                end
                ST_FROZEN: begin
                    if (stage_valid_q && out_deq__ENA) begin
                        if (word_idx_q == WIW'(NWORDS - 1)) begin
                            word_idx_d    = '0;
                            stage_valid_d = 1'b0;
                            rptr_d        = rptr_q + 1'b1;
                            count_d       = count_q - 1'b1;
                        end else begin
                            word_idx_d = word_idx_q + 1'b1;
                        end
                    end
                    // Two-step prefetch: issue the BRAM read, then latch it.
                    if (rd_pending_q) begin
                        stage_d       = rd_data_q;
                        stage_valid_d = 1'b1;
                        rd_pending_d  = 1'b0;
                    end else if (!stage_valid_q && (count_q != '0)) begin
                        rd_issue     = 1'b1;
                        rd_pending_d = 1'b1;
                    end
                    if ((count_d == '0) && !stage_valid_d && !rd_pending_d) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= ST_IDLE;
            ts_q          <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                last_q[c] <= '0;
                hold_q[c] <= '0;
            end
            last_valid_q  <= '0;
            hold_valid_q  <= '0;
            rr_next_q     <= '0;
            wptr_q        <= '0;
            rptr_q        <= '0;
            count_q       <= '0;
            dropped_q     <= '0;
            wrapped_q     <= 1'b0;
            ring_q        <= 1'b0;
            stage_q       <= '0;
            stage_valid_q <= 1'b0;
            word_idx_q    <= '0;
            rd_pending_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            ts_q          <= ts_d;
            last_q        <= last_d;
            hold_q        <= hold_d;
            last_valid_q  <= last_valid_d;
            hold_valid_q  <= hold_valid_d;
            rr_next_q     <= rr_next_d;
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            count_q       <= count_d;
            dropped_q     <= dropped_d;
            wrapped_q     <= wrapped_d;
            ring_q        <= ring_d;
            stage_q       <= stage_d;
            stage_valid_q <= stage_valid_d;
            word_idx_q    <= word_idx_d;
            rd_pending_q  <= rd_pending_d;
        end
    end

    // Plain BRAM: no reset, one write and one registered read port.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wptr_q] <= hold_q[grant];
        end
        if (rd_issue) begin
            rd_data_q <= mem[rptr_q];
        end
    end

    assign out_first      = stage_valid_q ? stage_words[word_idx_q] : '0;
    assign out_first__RDY = stage_valid_q;
    assign out_deq__RDY   = stage_valid_q;
    assign status_state   = state_q;
    assign status_count   = count_q;
    assign status_dropped = dropped_q;
    assign status_wrapped = wrapped_q;

endmodule

// File: tb/tb_trace_multi.sv
`timescale 1ns/1ps
// Directed testbench for trace_multi with a 16-entry ring.
module tb_trace_multi;

    localparam int CH = 4;
    localparam int W  = 64;
    localparam int D  = 16;

    logic            CLK;
    logic            RST;
    logic [CH-1:0]   probe_enable;
    logic [CH*W-1:0] probe_data;
    logic            ctl_arm__ENA;
    logic            ctl_stop__ENA;
    logic            ctl_ring;
    logic [31:0]     out_first;
    logic            out_first__RDY;
    logic            out_deq__ENA;
    logic            out_deq__RDY;
    logic [1:0]      status_state;
    logic [4:0]      status_count;
    logic [15:0]     status_dropped;
    logic            status_wrapped;

    logic [W-1:0]    chData [CH];
    int              checkCount;
    int              errorCount;

    trace_multi #(
        .CHANNELS(CH), .WIDTH(W), .DEPTH(D), .SENSITIVITY(32), .OWIDTH(32)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .probe_enable(probe_enable),
        .probe_data(probe_data),
        .ctl_arm__ENA(ctl_arm__ENA),
        .ctl_stop__ENA(ctl_stop__ENA),
        .ctl_ring(ctl_ring),
        .out_first(out_first),
        .out_first__RDY(out_first__RDY),
        .out_deq__ENA(out_deq__ENA),
        .out_deq__RDY(out_deq__RDY),
        .status_state(status_state),
        .status_count(status_count),
        .status_dropped(status_dropped),
        .status_wrapped(status_wrapped)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic [CH-1:0] en);
        probe_enable = en;
        probe_data   = {chData[3], chData[2], chData[1], chData[0]};
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            errorCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic waitReady(input string tag);
        int n;
        n = 0;
        while (!out_first__RDY && n < 20) begin
            tick();
            n++;
        end
        checkOutput({tag, "_rdy"}, 64'(out_first__RDY), 64'd1);
    endtask

    task automatic readWord(input string tag, input logic [31:0] expected);
        waitReady(tag);
        checkOutput(tag, 64'(out_first), 64'(expected));
        out_deq__ENA = 1'b1;
        tick();
        out_deq__ENA = 1'b0;
    endtask

    task automatic readEntry(input string tag, input logic [7:0] chan, input logic [23:0] ts,
                             input logic [31:0] upper, input logic [31:0] lower);
        readWord({tag, "_hdr"}, {chan, ts});
        readWord({tag, "_hi"}, upper);
        readWord({tag, "_lo"}, lower);
    endtask

    task automatic armCapture(input logic ringMode);
        ctl_arm__ENA = 1'b1;
        ctl_ring     = ringMode;
        tick();
        ctl_arm__ENA = 1'b0;
    endtask

    task automatic stopCapture();
        ctl_stop__ENA = 1'b1;
        tick();
        ctl_stop__ENA = 1'b0;
    endtask

    initial begin
        checkCount    = 0;
        errorCount    = 0;
        RST           = 1'b1;
        ctl_arm__ENA  = 1'b0;
        ctl_stop__ENA = 1'b0;
        ctl_ring      = 1'b0;
        out_deq__ENA  = 1'b0;
        for (int c = 0; c < CH; c++) chData[c] = '0;
        applyStimulus('0);
        repeat (3) tick();

        // Reset values
        checkOutput("rst_state",   64'(status_state),   64'd0);
        checkOutput("rst_count",   64'(status_count),   64'd0);
        checkOutput("rst_dropped", 64'(status_dropped), 64'd0);
        checkOutput("rst_wrapped", 64'(status_wrapped), 64'd0);
        checkOutput("rst_rdy",     64'(out_first__RDY), 64'd0);
        checkOutput("rst_deqrdy",  64'(out_deq__RDY),   64'd0);
        checkOutput("rst_first",   64'(out_first),      64'd0);
        RST = 1'b0;
        tick();

        // Constant sample held 5 cycles gives one entry
        armCapture(1'b0);
        checkOutput("t1_capture", 64'(status_state), 64'd1);
        chData[0] = 64'h1111_2222_0000_0001;
        applyStimulus(4'b0001);
        repeat (5) tick();
        applyStimulus('0);
        tick();
        checkOutput("t1_count", 64'(status_count), 64'd1);
        stopCapture();
        checkOutput("t1_frozen", 64'(status_state), 64'd2);
        readEntry("t1", 8'h00, 24'd0, 32'h1111_2222, 32'h0000_0001);
        tick();
        checkOutput("t1_idle", 64'(status_state), 64'd0);

        // Lower-bit changes are below the sensitivity window
        armCapture(1'b0);
        for (int i = 0; i < 5; i++) begin
            chData[0] = {32'hAAAA_0000, 32'(i)};
            applyStimulus(4'b0001);
            tick();
        end
        applyStimulus('0);
        tick();
        checkOutput("t2_count1", 64'(status_count), 64'd1);

        // Upper-bit changes every cycle: consecutive timestamps
        armCapture(1'b0);
        for (int i = 0; i < 10; i++) begin
            chData[0] = {32'h1000_0000 + 32'(i), 32'(i)};
            applyStimulus(4'b0001);
            tick();
        end
        applyStimulus('0);
        tick();
        checkOutput("t2_count10", 64'(status_count), 64'd10);
        stopCapture();
        for (int i = 0; i < 10; i++) begin
            readEntry($sformatf("t2_e%0d", i), 8'h00, 24'(i), 32'h1000_0000 + 32'(i), 32'(i));
        end
        tick();
        checkOutput("t2_idle", 64'(status_state), 64'd0);

        // All channels change twice; second wave mostly dropped
        armCapture(1'b0);
        for (int c = 0; c < CH; c++) chData[c] = {32'hA000_0000 + 32'(c), 32'h0};
        applyStimulus(4'hF);
        tick();
        for (int c = 0; c < CH; c++) chData[c] = {32'hB000_0000 + 32'(c), 32'h1};
        applyStimulus(4'hF);
        tick();
        applyStimulus('0);
        repeat (6) tick();
        checkOutput("t3_count",   64'(status_count),   64'd5);
        checkOutput("t3_dropped", 64'(status_dropped), 64'd3);
        stopCapture();
        out_deq__ENA = 1'b1;
        tick();
        out_deq__ENA = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k < 4)
                readEntry($sformatf("t3_e%0d", k), 8'(k), 24'd0, 32'hA000_0000 + 32'(k), 32'h0);
            else
                readEntry("t3_e4", 8'h00, 24'd1, 32'hB000_0000, 32'h1);
        end
        tick();
        checkOutput("t3_idle", 64'(status_state), 64'd0);

        // One-shot fill freezes at DEPTH
        armCapture(1'b0);
        for (int n = 1; n <= 20; n++) begin
            chData[1] = {32'hD000_0000 + 32'(n), 32'(n)};
            applyStimulus(4'b0010);
            tick();
        end
        applyStimulus('0);
        tick();
        checkOutput("t4_state",   64'(status_state),   64'd2);
        checkOutput("t4_count",   64'(status_count),   64'd16);
        checkOutput("t4_wrapped", 64'(status_wrapped), 64'd0);
        readWord("t4_hdr", 32'h0100_0000);
        readWord("t4_hi",  32'hD000_0001);

        // Arm together with stop mid-entry: arm wins, readout discarded
        ctl_arm__ENA  = 1'b1;
        ctl_stop__ENA = 1'b1;
        ctl_ring      = 1'b1;
        tick();
        ctl_arm__ENA  = 1'b0;
        ctl_stop__ENA = 1'b0;
        checkOutput("t5_state", 64'(status_state),   64'd1);
        checkOutput("t5_count", 64'(status_count),   64'd0);
        checkOutput("t5_rdy",   64'(out_first__RDY), 64'd0);

        // Ring overwrite: 20 samples into 16 entries
        for (int n = 1; n <= 20; n++) begin
            chData[1] = {32'hC000_0000 + 32'(n), 32'(n)};
            applyStimulus(4'b0010);
            tick();
        end
        applyStimulus('0);
        repeat (2) tick();
        checkOutput("t5_ringcount", 64'(status_count),   64'd16);
        checkOutput("t5_wrapped",   64'(status_wrapped), 64'd1);
        checkOutput("t5_ringstate", 64'(status_state),   64'd1);
        stopCapture();
        readEntry("t5_oldest", 8'h01, 24'd4, 32'hC000_0005, 32'h0000_0005);
        checkOutput("t5_count15", 64'(status_count), 64'd15);

        // Reset during capture
        armCapture(1'b0);
        for (int c = 0; c < CH; c++) chData[c] = {32'h5000_0000 + 32'(c), 32'h0};
        applyStimulus(4'hF);
        tick();
        for (int c = 0; c < CH; c++) chData[c] = {32'h6000_0000 + 32'(c), 32'h0};
        applyStimulus(4'hF);
        tick();
        checkOutput("t6_predrop", 64'(status_dropped), 64'd3);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        applyStimulus('0);
        checkOutput("t6_state",   64'(status_state),   64'd0);
        checkOutput("t6_count",   64'(status_count),   64'd0);
        checkOutput("t6_dropped", 64'(status_dropped), 64'd0);
        checkOutput("t6_wrapped", 64'(status_wrapped), 64'd0);
        checkOutput("t6_rdy",     64'(out_first__RDY), 64'd0);
        checkOutput("t6_first",   64'(out_first),      64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
